// File: rtl/regfile_csr.sv
// Write-back state sink: 32x32 GPR file, machine-mode CSRs and the 64-bit mcycle counter.
// Define WB_BYPASS_EN to forward same-cycle write-back data onto the read ports.
module regfile_csr #(
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_reg_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_valD,
    input  logic [11:0] wb_csr_rd,
    input  logic [2:0]  wb_csr_sel,
    input  logic [31:0] wb_csr_wdata,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [11:0] csr_raddr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MCYC_LO = 12'hB00;
    localparam logic [11:0] ADDR_MCYC_HI = 12'hB80;

    logic [31:0] gpr_r [32];
    logic [31:0] mstatus_r;
    logic [31:0] mtvec_r;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic [63:0] mcycle_r;
    logic [63:0] mcycle_inc_s;
    logic [63:0] mcycle_nxt_s;
    logic        csr_wr_s;
    logic        ecall_s;
    logic        mret_s;
    logic [31:0] csr_stored_s;

`ifdef WB_BYPASS_EN
    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MTVEC, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MCYC_LO, ADDR_MCYC_HI: csr_implemented = 1'b1;
            default:                                 csr_implemented = 1'b0;
        endcase
    endfunction
`endif

    // Decode the write-back CSR op; reserved encodings behave as no-op
    always_comb begin
        csr_wr_s = 1'b0;
        ecall_s  = 1'b0;
        mret_s   = 1'b0;
        case (wb_csr_sel)
            3'b001:  csr_wr_s = 1'b1;
            3'b010:  ecall_s  = 1'b1;
            3'b100:  mret_s   = 1'b1;
            default: csr_wr_s = 1'b0;
        endcase
    end

    // GPR write port; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr_r[i] <= 32'd0;
            end
        end else if (wb_reg_wen && (wb_rd != 5'd0)) begin
            gpr_r[wb_rd] <= wb_valD;
        end
    end

    // Trap CSRs: explicit writes, ecall entry and mret exit (MIE is bit 3, MPIE bit 7)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= 32'd0;
            mepc_r    <= 32'd0;
            mcause_r  <= 32'd0;
        end else if (csr_wr_s) begin
            case (wb_csr_rd)
                ADDR_MSTATUS: mstatus_r <= wb_csr_wdata;
                ADDR_MTVEC:   mtvec_r   <= wb_csr_wdata;
                ADDR_MEPC:    mepc_r    <= wb_csr_wdata;
                ADDR_MCAUSE:  mcause_r  <= wb_csr_wdata;
                default:      mcause_r  <= mcause_r;
            endcase
        end else if (ecall_s) begin
            mepc_r    <= wb_csr_wdata;
            mcause_r  <= ECALL_CAUSE;
            mstatus_r <= {mstatus_r[31:8], mstatus_r[3], mstatus_r[6:4], 1'b0, mstatus_r[2:0]};
        end else if (mret_s) begin
            mstatus_r <= {mstatus_r[31:8], 1'b1, mstatus_r[6:4], mstatus_r[7], mstatus_r[2:0]};
        end
    end

    // mcycle next value: a written half takes the data, the other keeps the full 64-bit increment
    always_comb begin
        mcycle_inc_s = mcycle_r + 64'd1;
        mcycle_nxt_s = mcycle_inc_s;
        if (csr_wr_s && (wb_csr_rd == ADDR_MCYC_LO)) begin
            mcycle_nxt_s[31:0] = wb_csr_wdata;
        end else if (csr_wr_s && (wb_csr_rd == ADDR_MCYC_HI)) begin
            mcycle_nxt_s[63:32] = wb_csr_wdata;
        end else begin
            mcycle_nxt_s = mcycle_inc_s;
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_r <= 64'd0;
        end else begin
            mcycle_r <= mcycle_nxt_s;
        end
    end

    // Read port 1
    always_comb begin
        rs1_data = 32'd0;
        if (rs1_addr == 5'd0) begin
            rs1_data = 32'd0;
`ifdef WB_BYPASS_EN
        end else if (wb_reg_wen && (wb_rd == rs1_addr)) begin
            rs1_data = wb_valD;
`endif
        end else begin
            rs1_data = gpr_r[rs1_addr];
        end
    end

    // Read port 2
    always_comb begin
        rs2_data = 32'd0;
        if (rs2_addr == 5'd0) begin
            rs2_data = 32'd0;
`ifdef WB_BYPASS_EN
        end else if (wb_reg_wen && (wb_rd == rs2_addr)) begin
            rs2_data = wb_valD;
`endif
        end else begin
            rs2_data = gpr_r[rs2_addr];
        end
    end

    // CSR read mux; unimplemented addresses read as zero
    always_comb begin
        csr_stored_s = 32'd0;
        case (csr_raddr)
            ADDR_MSTATUS: csr_stored_s = mstatus_r;
            ADDR_MTVEC:   csr_stored_s = mtvec_r;
            ADDR_MEPC:    csr_stored_s = mepc_r;
            ADDR_MCAUSE:  csr_stored_s = mcause_r;
            ADDR_MCYC_LO: csr_stored_s = mcycle_r[31:0];
            ADDR_MCYC_HI: csr_stored_s = mcycle_r[63:32];
            default:      csr_stored_s = 32'd0;
        endcase
    end

    // CSR and trap-vector outputs, forwarded from write-back when bypass is built in
    always_comb begin
        mtvec_o = mtvec_r;
`ifdef WB_BYPASS_EN
        if (csr_wr_s && (wb_csr_rd == csr_raddr) && csr_implemented(csr_raddr)) begin
            csr_rdata = wb_csr_wdata;
        end else begin
            csr_rdata = csr_stored_s;
        end
        if (ecall_s) begin
            mepc_o = wb_csr_wdata;
        end else begin
            mepc_o = mepc_r;
        end
`else
        csr_rdata = csr_stored_s;
        mepc_o    = mepc_r;
`endif
    end

endmodule

// File: tb/tb_regfile_csr.sv
// Directed and randomized bench for regfile_csr against an architectural reference model.
module tb_regfile_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_reg_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_valD;
    logic [11:0] wb_csr_rd;
    logic [2:0]  wb_csr_sel;
    logic [31:0] wb_csr_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [11:0] csr_raddr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] csr_rdata;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] gpr_m [32];
    logic [31:0] mstatus_m, mtvec_m, mepc_m, mcause_m;
    logic [63:0] mcycle_m;
    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'h7C0};

    regfile_csr dut (
        .clk(clk), .rst(rst), .wb_reg_wen(wb_reg_wen), .wb_rd(wb_rd), .wb_valD(wb_valD),
        .wb_csr_rd(wb_csr_rd), .wb_csr_sel(wb_csr_sel), .wb_csr_wdata(wb_csr_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .csr_raddr(csr_raddr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_rdata(csr_rdata),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stored_csr(input logic [11:0] a);
        if (a == 12'h300) return mstatus_m;
        if (a == 12'h305) return mtvec_m;
        if (a == 12'h341) return mepc_m;
        if (a == 12'h342) return mcause_m;
        if (a == 12'hB00) return mcycle_m[31:0];
        if (a == 12'hB80) return mcycle_m[63:32];
        return 32'd0;
    endfunction

    function automatic bit is_csr(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) ||
               (a == 12'h342) || (a == 12'hB00) || (a == 12'hB80);
    endfunction

    function automatic logic [31:0] exp_gpr(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_reg_wen && wb_rd == a) return wb_valD;
`endif
        return gpr_m[a];
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] a);
`ifdef WB_BYPASS_EN
        if (wb_csr_sel == 3'b001 && wb_csr_rd == a && is_csr(a)) return wb_csr_wdata;
`endif
        return stored_csr(a);
    endfunction

    function automatic logic [31:0] exp_mepc();
`ifdef WB_BYPASS_EN
        if (wb_csr_sel == 3'b010) return wb_csr_wdata;
`endif
        return mepc_m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) gpr_m[i] = 32'd0;
        mstatus_m = 32'h0000_1800;
        mtvec_m   = 32'd0;
        mepc_m    = 32'd0;
        mcause_m  = 32'd0;
        mcycle_m  = 64'd0;
    endtask

    // Architectural effect of one rising clock edge with the currently driven inputs
    task automatic model_edge();
        logic [63:0] nxt;
        if (rst) begin
            model_reset();
            return;
        end
        if (wb_reg_wen && wb_rd != 5'd0) gpr_m[wb_rd] = wb_valD;
        nxt = mcycle_m + 64'd1;
        if (wb_csr_sel == 3'b001) begin
            if (wb_csr_rd == 12'h300) mstatus_m = wb_csr_wdata;
            if (wb_csr_rd == 12'h305) mtvec_m   = wb_csr_wdata;
            if (wb_csr_rd == 12'h341) mepc_m    = wb_csr_wdata;
            if (wb_csr_rd == 12'h342) mcause_m  = wb_csr_wdata;
            if (wb_csr_rd == 12'hB00) nxt[31:0]  = wb_csr_wdata;
            if (wb_csr_rd == 12'hB80) nxt[63:32] = wb_csr_wdata;
        end else if (wb_csr_sel == 3'b010) begin
            mepc_m       = wb_csr_wdata;
            mcause_m     = 32'd11;
            mstatus_m[7] = mstatus_m[3];
            mstatus_m[3] = 1'b0;
        end else if (wb_csr_sel == 3'b100) begin
            mstatus_m[3] = mstatus_m[7];
            mstatus_m[7] = 1'b1;
        end
        mcycle_m = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_reg_wen = 1'b0;
        wb_csr_sel = 3'b000;
    endtask

    task automatic csr_op(input logic [2:0] sel, input logic [11:0] a, input logic [31:0] d);
        wb_csr_sel = sel; wb_csr_rd = a; wb_csr_wdata = d;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rs1"}, rs1_data, exp_gpr(rs1_addr));
        chk({tag, ".rs2"}, rs2_data, exp_gpr(rs2_addr));
        chk({tag, ".csr"}, csr_rdata, exp_csr(csr_raddr));
        chk({tag, ".mtvec"}, mtvec_o, mtvec_m);
        chk({tag, ".mepc"}, mepc_o, exp_mepc());
    endtask

    task automatic read_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; wb_reg_wen = 1'b0; wb_rd = 5'd0; wb_valD = 32'd0;
        wb_csr_rd = 12'd0; wb_csr_sel = 3'b000; wb_csr_wdata = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; csr_raddr = 12'h300;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all("init");

        // Async reset mid-cycle, with a write held across the reset edge
        wb_reg_wen = 1'b1; wb_rd = 5'd3; wb_valD = 32'hA5A5_0003;
        csr_op(3'b001, 12'h300, 32'h0000_0000);
        cycle();
        idle();
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        check_all("pre_rst");
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.rs1", rs1_data, 32'd0);
        chk("rst.rs2", rs2_data, 32'd0);
        read_csr("rst.mstatus", 12'h300, 32'h0000_1800);
        read_csr("rst.mcycle", 12'hB00, 32'd0);
        wb_reg_wen = 1'b1; wb_rd = 5'd4; wb_valD = 32'h1111_2222;
        cycle();
        rst = 1'b0;
        idle();
        rs1_addr = 5'd4;
        #1;
        chk("rst.drop_write", rs1_data, 32'd0);

        // x0 is hardwired to zero
        wb_reg_wen = 1'b1; wb_rd = 5'd0; wb_valD = 32'hDEAD_BEEF; rs1_addr = 5'd0;
        cycle();
        #1;
        chk("x0.read", rs1_data, 32'd0);
        wb_rd = 5'd5;
        cycle();
        idle();
        rs2_addr = 5'd5;
        #1;
        chk("x5.read", rs2_data, 32'hDEAD_BEEF);

        // Same-cycle write/read of one register
        wb_reg_wen = 1'b1; wb_rd = 5'd7; wb_valD = 32'h0000_1234; rs1_addr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        chk("bypass.same", rs1_data, 32'h0000_1234);
`else
        chk("bypass.same", rs1_data, 32'd0);
`endif
        cycle();
        idle();
        #1;
        chk("bypass.next", rs1_data, 32'h0000_1234);

        // ecall then mret
        csr_op(3'b001, 12'h300, 32'h0000_1808);
        cycle();
        csr_op(3'b010, 12'h305, 32'h8000_0010);
        check_all("ecall.during");
        cycle();
        idle();
        read_csr("ecall.mepc", 12'h341, 32'h8000_0010);
        read_csr("ecall.mcause", 12'h342, 32'd11);
        read_csr("ecall.mstatus", 12'h300, 32'h0000_1880);
        chk("ecall.mtvec", mtvec_o, 32'd0);
        chk("ecall.mepc_o", mepc_o, 32'h8000_0010);
        csr_op(3'b100, 12'h341, 32'h0);
        cycle();
        idle();
        read_csr("mret.mstatus", 12'h300, 32'h0000_1888);
        read_csr("mret.mepc", 12'h341, 32'h8000_0010);

        // mcycle carry, write-over-increment, and 64-bit wrap
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF);
        cycle();
        idle();
        read_csr("mcyc.lo_written", 12'hB00, 32'hFFFF_FFFF);
        read_csr("mcyc.hi_zero", 12'hB80, 32'd0);
        cycle();
        read_csr("mcyc.carry_lo", 12'hB00, 32'd0);
        read_csr("mcyc.carry_hi", 12'hB80, 32'd1);
        csr_op(3'b001, 12'hB80, 32'h0000_ABCD);
        cycle();
        idle();
        read_csr("mcyc.hi_written", 12'hB80, 32'h0000_ABCD);
        read_csr("mcyc.lo_inc", 12'hB00, 32'd1);
        csr_op(3'b001, 12'hB80, 32'hFFFF_FFFF);
        cycle();
        csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF);
        cycle();
        idle();
        read_csr("mcyc.all_ones", 12'hB80, 32'hFFFF_FFFF);
        cycle();
        read_csr("mcyc.wrap_hi", 12'hB80, 32'd0);
        read_csr("mcyc.wrap_lo", 12'hB00, 32'd0);

        // Unimplemented CSR address
        csr_op(3'b001, 12'h7C0, 32'h5555_5555);
        read_csr("unimpl.same", 12'h7C0, 32'd0);
        cycle();
        idle();
        read_csr("unimpl.after", 12'h7C0, 32'd0);
        csr_raddr = 12'h300;
        check_all("unimpl.state");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            wb_reg_wen   = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 31));
            wb_valD      = $urandom;
            wb_csr_sel   = 3'($urandom_range(0, 7));
            wb_csr_rd    = addrs[$urandom_range(0, 6)];
            wb_csr_wdata = $urandom;
            rs1_addr     = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
            rs2_addr     = 5'($urandom_range(0, 31));
            csr_raddr    = ($urandom_range(0, 3) == 0) ? wb_csr_rd : addrs[$urandom_range(0, 6)];
            check_all("rand");
            cycle();
        end
        idle();
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
